// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result handshake between the control unit and the divider
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output div_start, dividend, divisor,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  div_start, dividend, divisor,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed restoring divider, hi=remainder lo=quotient
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic             w_last_step;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;

    // Plain unsigned negate: the most negative value maps onto itself, which the
    // unsigned quotient path handles correctly.
    assign w_dvd_mag   = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign w_dvs_mag   = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
    assign w_dvs_zero  = (bus.divisor == '0);
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shift - {2'b00, r_dvs};
    assign w_borrow = w_trial[WIDTH+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.div_start && !w_dvs_zero) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last_step) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.div_start) begin
                        if (w_dvs_zero) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_quo    <= w_dvd_mag;
                            r_dvs    <= w_dvs_mag;
                            r_rem    <= '0;
                            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r <= bus.dividend[WIDTH-1];
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (w_borrow) begin
                        r_rem <= w_shift[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_lo   <= r_sign_q ? (~r_quo + WIDTH'(1)) : r_quo;
                    r_hi   <= r_sign_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vectors for div_unit with hand-computed results
module tb_div_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int   r_lat;
    int   r_bcnt;
    logic r_dz;
    int   n_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; edge T is the next rising edge.
    // inj > 0 pulses a 50/5 request so that it is sampled at edge T+inj.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inj);
        dif.dividend  = a;
        dif.divisor   = b;
        dif.div_start = 1'b1;
        r_lat  = -1;
        r_bcnt = 0;
        r_dz   = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) dif.div_start = 1'b0;
            if (inj > 0 && k == inj - 1) begin
                dif.dividend  = 32'd50;
                dif.divisor   = 32'd5;
                dif.div_start = 1'b1;
            end
            if (inj > 0 && k == inj) dif.div_start = 1'b0;
            if (dif.busy) r_bcnt++;
            if (dif.done) begin
                r_lat = k;
                r_dz  = dif.div_zero;
                break;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        dif.div_start = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_busy", {31'd0, dif.busy}, 32'd0);
        check_val("rst_done", {31'd0, dif.done}, 32'd0);
        check_val("rst_dz",   {31'd0, dif.div_zero}, 32'd0);
        check_val("rst_hi",   dif.hi, 32'd0);
        check_val("rst_lo",   dif.lo, 32'd0);

        run_div(32'd100, 32'd7, 0);
        check_val("pos_lat",  r_lat, 32'd33);
        check_val("pos_busy", r_bcnt, 32'd33);
        check_val("pos_dz",   {31'd0, r_dz}, 32'd0);
        check_val("pos_lo",   dif.lo, 32'd14);
        check_val("pos_hi",   dif.hi, 32'd2);

        run_div(-32'sd7, 32'd2, 0);
        check_val("neg_a_lo", dif.lo, 32'hFFFF_FFFD);
        check_val("neg_a_hi", dif.hi, 32'hFFFF_FFFF);

        run_div(32'd7, -32'sd2, 0);
        check_val("neg_b_lo", dif.lo, 32'hFFFF_FFFD);
        check_val("neg_b_hi", dif.hi, 32'd1);

        run_div(32'd59, 32'd6, 0);
        check_val("pre_lo", dif.lo, 32'd9);
        check_val("pre_hi", dif.hi, 32'd5);

        run_div(32'd5, 32'd0, 0);
        check_val("dz_lat",  r_lat, 32'd0);
        check_val("dz_flag", {31'd0, r_dz}, 32'd1);
        check_val("dz_busy", r_bcnt, 32'd0);
        check_val("dz_hi",   dif.hi, 32'd5);
        check_val("dz_lo",   dif.lo, 32'd9);
        @(negedge clk);
        check_val("dz_done_pulse", {31'd0, dif.done}, 32'd0);
        check_val("dz_flag_pulse", {31'd0, dif.div_zero}, 32'd0);
        check_val("dz_busy_after", {31'd0, dif.busy}, 32'd0);

        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_val("ovf_lat", r_lat, 32'd33);
        check_val("ovf_dz",  {31'd0, r_dz}, 32'd0);
        check_val("ovf_lo",  dif.lo, 32'h8000_0000);
        check_val("ovf_hi",  dif.hi, 32'd0);

        run_div(32'd100, 32'd7, 10);
        check_val("inj_lat", r_lat, 32'd33);
        check_val("inj_lo",  dif.lo, 32'd14);
        check_val("inj_hi",  dif.hi, 32'd2);

        // Issued in the done cycle of the previous operation.
        run_div(-32'sd100, 32'd7, 0);
        check_val("b2b_lat", r_lat, 32'd33);
        check_val("b2b_lo",  dif.lo, 32'hFFFF_FFF2);
        check_val("b2b_hi",  dif.hi, 32'hFFFF_FFFE);

        dif.dividend  = 32'd100;
        dif.divisor   = 32'd7;
        dif.div_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) dif.div_start = 1'b0;
        end
        @(posedge clk);
        reset = 1'b1;
        #1;
        check_val("mrst_busy", {31'd0, dif.busy}, 32'd0);
        check_val("mrst_done", {31'd0, dif.done}, 32'd0);
        check_val("mrst_hi",   dif.hi, 32'd0);
        check_val("mrst_lo",   dif.lo, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dif.done) n_done++;
        end
        check_val("mrst_no_done", n_done, 32'd0);

        run_div(32'd9, 32'd3, 0);
        check_val("post_lat", r_lat, 32'd33);
        check_val("post_lo",  dif.lo, 32'd3);
        check_val("post_hi",  dif.hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed divider serving the multicycle control unit's DIV request/wait handshake.
- Control unit pulses div_start and holds its wait state until done.
- Results go to hi (remainder) and lo (quotient) for MFHI/MFLO.
- div_zero feeds the control unit's DivZero exception input.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- div_start  input  1  one-cycle request from control unit; sampled only in IDLE.
- dividend  input  WIDTH  rs value, signed two's complement; sampled on the div_start edge.
- divisor  input  WIDTH  rt value, signed; sampled on the div_start edge.
- busy  output  1  division in progress.
- done  output  1  one-cycle completion pulse (normal or divide-by-zero).
- div_zero  output  1  one-cycle pulse, coincident with done, when divisor == 0.
- hi  output  WIDTH  remainder register.
- lo  output  WIDTH  quotient register.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, internal regs=0.
- Outputs are registered.
- done and div_zero are high for exactly one cycle per accepted request.
- States:
  - IDLE: done=0, div_zero=0 unless set this edge. On div_start at edge T:
    - if divisor==0: done=1 and div_zero=1 after edge T; hi/lo unchanged; stay IDLE; busy stays 0.
    - else: latch |dividend| and |divisor| (unsigned WIDTH-bit magnitudes), sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB]; clear partial remainder; counter=0; busy=1; go to CALC.
  - CALC: one restoring step per edge.
    - Shift {rem,quo} left by 1, bringing in the next dividend bit.
    - Trial subtract the divisor magnitude; if no borrow, keep the difference and set quo LSB=1, else restore.
    - Increment counter; after the WIDTH-th step (edge T+WIDTH) go to FIX.
  - FIX (edge T+WIDTH+1):
    - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
    - done=1, busy=0, return to IDLE.
- Latency: with WIDTH=32, start at edge T gives results and done valid in the cycle after edge T+33.
- Divide-by-zero: response after one edge.
- Sign rules: quotient truncates toward zero; remainder takes the dividend's sign; dividend == lo*divisor + hi.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no exception flag.
- div_start while busy: ignored, no restart, no effect on the in-flight result.
- div_start in the same cycle done is high: accepted, since state is IDLE.
- hi/lo hold their value between operations and change only in FIX. Divide-by-zero leaves them unchanged.
- Reset mid-operation: aborts immediately to the reset values; no done pulse.
- Dividend magnitude uses an unsigned WIDTH-bit negate, so 0x80000000 stays 0x80000000. Remainder register is WIDTH+1 bits internally to hold the borrow.

Test Plan:
- Positive operands: 100 / 7 with div_start at edge T -> busy=1 from T to T+33; done=1 for one cycle after edge T+33 with lo=14, hi=2, div_zero=0.
- Mixed signs: -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7 / -2 -> lo=-3, hi=1.
- Divide by zero: preload hi=5, lo=9, then 5 / 0 -> done=1 and div_zero=1 after exactly one edge; busy never asserts; hi=5, lo=9 unchanged.
- Overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0, latency 33.
- Start while busy: start 100/7, pulse div_start with 50/5 at edge T+10 -> ignored; result lo=14, hi=2 at T+33. Back-to-back: new start accepted in the done cycle.
- Reset mid-operation: assert reset at edge T+15 -> busy=0, hi=0, lo=0 immediately; no done pulse. A subsequent 9 / 3 gives lo=3, hi=0 at normal latency.
